// File: rtl/logicnb_pipe_if.sv
// rtl/logicnb_pipe_if.sv - operation/result handshake bundle for logicnb_pipe
// Optional parity signal is present only when LOGICNB_PARITY_EN is defined.
interface logicnb_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
`ifdef LOGICNB_PARITY_EN
  logic             parity;
`endif

  modport master (
    output in_valid, a, b, op, out_ready,
`ifdef LOGICNB_PARITY_EN
    input  parity,
`endif
    input  in_ready, out_valid, y, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
`ifdef LOGICNB_PARITY_EN
    output parity,
`endif
    output in_ready, out_valid, y, zero
  );
endinterface

// File: rtl/logicnb_pipe.sv
// rtl/logicnb_pipe.sv - elastic STAGES-deep pipeline computing bitwise XOR/AND/OR/XNOR
// Optional parity output is built only when LOGICNB_PARITY_EN is defined.
module logicnb_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  logicnb_pipe_if.slave  bus
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("logicnb_pipe: WIDTH must be in 1..64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("logicnb_pipe: STAGES must be in 1..4");
    end
  endgenerate

  logic [WIDTH-1:0]  res;
  logic              in_ready;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] vin;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [WIDTH-1:0]  din [STAGES];
  logic              zero_q;

  // The result is formed at the handshake, so later operand changes cannot leak in.
  always_comb begin
    res = '0;
    case (bus.op)
      2'b00:   res = bus.a ^ bus.b;
      2'b01:   res = bus.a & bus.b;
      2'b10:   res = bus.a | bus.b;
      default: res = ~(bus.a ^ bus.b);
    endcase
  end

  // Stage k may load if the output drains or any stage from k onward has a hole.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ld[k] = bus.out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!vld[j]) ld[k] = 1'b1;
      end
    end
  end

  assign in_ready = ld[0] & ~rst;

  always_comb begin
    vin[0] = bus.in_valid & in_ready;
    din[0] = res;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = vld[k-1];
      din[k] = dat[k-1];
    end
  end

  // Data words only move with a valid token, keeping y steady across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      zero_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          vld[k] <= vin[k];
          if (vin[k]) dat[k] <= din[k];
        end
      end
      if (ld[STAGES-1] && vin[STAGES-1]) zero_q <= ~|din[STAGES-1];
    end
  end

`ifdef LOGICNB_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (ld[STAGES-1] && vin[STAGES-1]) begin
      parity_q <= ^din[STAGES-1];
    end
  end

  assign bus.parity = parity_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.y         = dat[STAGES-1];
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_logicnb_pipe.sv
// tb/tb_logicnb_pipe.sv - scoreboard bench for logicnb_pipe (2-stage x16 and 4-stage x5)
// Parity checks are active only when LOGICNB_PARITY_EN is defined.
module tb_logicnb_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;

  logicnb_pipe_if #(.WIDTH(16)) bus ();
  logicnb_pipe_if #(.WIDTH(5))  bus2 ();

  logicnb_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logicnb_pipe #(.WIDTH(5), .STAGES(4)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  typedef struct {
    logic [15:0] y;
    logic        z;
    logic        p;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit lat_chk1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor for the 16-bit, 2-stage instance.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q1.size() == 0) begin
        chk("unexpected_out1", bus.out_valid, 0);
      end else begin
        e1 = q1[0];
        chk("y1", bus.y, e1.y);
        chk("zero1", bus.zero, e1.z);
`ifdef LOGICNB_PARITY_EN
        chk("parity1", bus.parity, e1.p);
`endif
        if (bus.out_ready) begin
          if (e1.lat) chk("latency1", cyc - e1.acc, 2);
          void'(q1.pop_front());
        end
      end
    end
  end

  // Monitor for the 5-bit, 4-stage instance.
  always @(negedge clk) begin
    if (!rst2 && bus2.out_valid) begin
      if (q2.size() == 0) begin
        chk("unexpected_out2", bus2.out_valid, 0);
      end else begin
        e2 = q2[0];
        chk("y2", bus2.y, e2.y[4:0]);
        chk("zero2", bus2.zero, e2.z);
`ifdef LOGICNB_PARITY_EN
        chk("parity2", bus2.parity, e2.p);
`endif
        if (bus2.out_ready) begin
          if (e2.lat) chk("latency2", cyc - e2.acc, 4);
          void'(q2.pop_front());
        end
      end
    end
  end

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input logic [15:0] ey, input bit must);
    exp_t e;
    int   n = 0;
    bit   done = 0;
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (must && n == 0) chk("in_ready_b2b1", bus.in_ready, 1);
      if (bus.in_ready) begin
        e.y = ey; e.z = (ey == 16'h0); e.p = ^ey; e.acc = cyc; e.lat = lat_chk1;
        q1.push_back(e);
        done = 1;
      end else if (++n > 50) begin
        chk("accept_timeout1", bus.in_ready, 1);
        done = 1;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op,
                       input logic [4:0] ey);
    exp_t e;
    bus2.a = a; bus2.b = b; bus2.op = op; bus2.in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_b2b2", bus2.in_ready, 1);
    if (bus2.in_ready) begin
      e.y = {11'h0, ey}; e.z = (ey == 5'h0); e.p = ^ey; e.acc = cyc; e.lat = 1'b1;
      q2.push_back(e);
    end
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   t;
    rst = 1'b1; rst2 = 1'b1; lat_chk1 = 1'b1;
    bus.in_valid  = 1'b0; bus.a  = '0; bus.b  = '0; bus.op  = 2'b00; bus.out_ready  = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.op = 2'b00; bus2.out_ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_in_ready2", bus2.in_ready, 0);
`ifdef LOGICNB_PARITY_EN
    chk("rst_parity", bus.parity, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);
    @(posedge clk); #1;

    // Single XOR with 2-cycle latency
    send1(16'hF0F0, 16'h0FF0, 2'b00, 16'hFF00, 0);
    repeat (4) @(posedge clk); #1;

    // Back-to-back AND / OR / XNOR and extra vectors
    send1(16'hAAAA, 16'h5555, 2'b01, 16'h0000, 1);
    send1(16'hAAAA, 16'h5555, 2'b10, 16'hFFFF, 1);
    send1(16'hAAAA, 16'h5555, 2'b11, 16'h0000, 1);
    send1(16'h1234, 16'h1234, 2'b11, 16'hFFFF, 1);
    send1(16'hFFFF, 16'h0001, 2'b00, 16'hFFFE, 1);
    repeat (4) @(posedge clk); #1;

    // Backpressure: third op must stall until out_ready returns
    lat_chk1 = 1'b0;
    bus.out_ready = 1'b0;
    send1(16'h00FF, 16'h0F0F, 2'b00, 16'h0FF0, 1);
    send1(16'h00FF, 16'h0F0F, 2'b01, 16'h000F, 1);
    bus.a = 16'h00FF; bus.b = 16'h0F0F; bus.op = 2'b10; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_full", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_release", bus.in_ready, 1);
    e.y = 16'h0FFF; e.z = 1'b0; e.p = ^e.y; e.acc = cyc; e.lat = 1'b0;
    q1.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Reset with two ops in flight: both are discarded
    bus.out_ready = 1'b0;
    send1(16'h1111, 16'h2222, 2'b10, 16'h3333, 1);
    send1(16'h1111, 16'h2222, 2'b00, 16'h3333, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_in_rst", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete();
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_y", bus.y, 0);
    chk("flush_zero", bus.zero, 1);
    chk("flush_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_out", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    lat_chk1 = 1'b1;
    send1(16'h0000, 16'h0000, 2'b11, 16'hFFFF, 0);

    // 5-bit, 4-stage instance
    send2(5'b10110, 5'b00011, 2'b00, 5'b10101);
    send2(5'b11111, 5'b11111, 2'b11, 5'b11111);
    send2(5'b10101, 5'b01010, 2'b01, 5'b00000);

    t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", q1.size() + q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
